// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states and the pc/instruction word types used
// by the fetch stage and the control unit.
package cpu_pkg;

  localparam int PC_WIDTH    = 13;
  localparam int INSTR_WIDTH = 16;
  localparam int CNT_WIDTH   = 16;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: holds the fetch address and advances only when the
// decoder accepts the current instruction (sequential or jump target).
module program_counter #(
  parameter int PC_WIDTH = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] jump_address,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next
);

  // pc + 1 wraps naturally at 2^PC_WIDTH
  assign pc_next = pc_load ? jump_address : pc + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pc <= '0;
    else if (load) pc <= pc_next;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding req/gnt + rvalid reads into an instruction
// register handed to the decoder with valid/ready.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int CNT_WIDTH   = cpu_pkg::CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    jump_address,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [CNT_WIDTH-1:0]   retired_count
);

  fetch_state_t          state, state_next;
  logic                  accept;
  logic                  req_d, valid_d, ld_instr;
  logic [PC_WIDTH-1:0]   addr_d, pc_next;

  assign accept = (state == S_VALID) && instr_ready;

  program_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
    .clk          (clk),
    .reset        (reset),
    .load         (accept),
    .pc_load      (pc_load),
    .jump_address (jump_address),
    .pc           (pc),
    .pc_next      (pc_next)
  );

  always_comb begin
    state_next = state;
    req_d      = imem_req;
    addr_d     = imem_addr;
    valid_d    = instr_valid;
    ld_instr   = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_REQ;
        req_d      = 1'b1;
        addr_d     = pc;
      end
      S_REQ: begin
        // rvalid is deliberately ignored here; only gnt moves us on
        if (imem_gnt) begin
          req_d      = 1'b0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          ld_instr   = 1'b1;
          valid_d    = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        // next request issues on the accept edge, giving 3 cycles/instr best case
        if (instr_ready) begin
          valid_d    = 1'b0;
          req_d      = 1'b1;
          addr_d     = pc_next;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instr_valid <= valid_d;
    end
  end

  // instruction keeps its last value after accept; instr_valid qualifies it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instruction <= '0;
    else if (ld_instr) instruction <= imem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             retired_count <= '0;
    else if (accept && ~&retired_count)    retired_count <= retired_count + 1'b1;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed stimulus pushes expected
// fetches/addresses, monitors pop and compare as the DUT presents them.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [12:0] jump_address;
  logic [12:0] pc;
  logic [15:0] retired_count;

  // small-counter instance used only to reach saturation quickly
  logic        sat_rst;
  logic        sat_req, sat_valid;
  logic [12:0] sat_addr, sat_pc;
  logic [15:0] sat_instr;
  logic [3:0]  sat_count;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_load(pc_load), .jump_address(jump_address), .pc(pc),
    .retired_count(retired_count)
  );

  instruction_fetch #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(sat_rst),
    .imem_req(sat_req), .imem_addr(sat_addr), .imem_gnt(1'b1),
    .imem_rvalid(1'b1), .imem_rdata(16'h0000),
    .instruction(sat_instr), .instr_valid(sat_valid), .instr_ready(1'b1),
    .pc_load(1'b0), .jump_address(13'h0000), .pc(sat_pc),
    .retired_count(sat_count)
  );

  typedef struct { logic [12:0] pc; logic [15:0] ins; } exp_t;
  exp_t        exp_q[$];
  logic [12:0] addr_q[$];
  logic [15:0] mem [8192];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory model: programmable gnt/rvalid latency, optional spurious rvalid
  int gnt_dly = 0, rv_dly = 0;
  bit spur = 1'b0;
  int mstate = 0, mcnt = 0;
  logic [12:0] maddr;
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b0;
      case (mstate)
        0: if (imem_req && !reset) begin
          maddr = imem_addr; mcnt = gnt_dly; mstate = 1;
          if (mcnt == 0) begin imem_gnt = 1'b1; mstate = 2; mcnt = rv_dly; end
        end
        1: begin
          mcnt--;
          if (mcnt == 0) begin imem_gnt = 1'b1; mstate = 2; mcnt = rv_dly; end
          else if (spur) begin imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; end
        end
        default: begin
          if (mcnt == 0) begin imem_rvalid = 1'b1; imem_rdata = mem[maddr]; mstate = 0; end
          else mcnt--;
        end
      endcase
    end
  end

  // accept monitor: pops expected fetch when the decoder takes one
  bit chk_period = 1'b0;
  int last_acc = -1;
  always @(negedge clk) begin
    #1;
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) chk("accept_unexpected", 32'(pc), 32'h7FFFFFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("accept_pc", 32'(pc), 32'(e.pc));
        chk("accept_instr", 32'(instruction), 32'(e.ins));
      end
      if (chk_period && last_acc >= 0) chk("period", 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
    end
  end

  // request monitor: new address on req rise, stable address while held
  logic        req_q = 1'b0;
  logic [12:0] held_addr = '0;
  always @(negedge clk) begin
    #1;
    if (!reset && imem_req && !req_q) begin
      if (addr_q.size() == 0) chk("req_unexpected", 32'(imem_addr), 32'h7FFFFFFF);
      else chk("req_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
    end else if (!reset && imem_req && req_q) begin
      chk("req_stable", 32'(imem_addr), 32'(held_addr));
    end
    req_q     = imem_req;
    held_addr = imem_addr;
  end

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (instr_valid) return;
      @(negedge clk);
    end
    chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic push(input logic [12:0] p, input logic [12:0] next_a);
    exp_t e;
    e.pc = p; e.ins = mem[p];
    exp_q.push_back(e);
    addr_q.push_back(next_a);
  endtask

  task automatic accept_pulse;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_load     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 37 + 16'h1111);
    mem[0] = 16'h4A10;
    mem[3] = 16'hA3FF;
    reset = 1'b1; sat_rst = 1'b1;
    instr_ready = 1'b1; pc_load = 1'b0; jump_address = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_count", 32'(retired_count), 0);

    // back-to-back fetches at addr 0,1,2
    addr_q.push_back(13'd0);
    push(13'd0, 13'd1); push(13'd1, 13'd2); push(13'd2, 13'd3);
    chk_period = 1'b1;
    reset = 1'b0; sat_rst = 1'b0;
    for (int i = 0; i < 40 && retired_count != 16'd3; i++) @(negedge clk);
    instr_ready = 1'b0;
    chk_period  = 1'b0;
    chk("count3", 32'(retired_count), 3);

    // decoder stall with A3FF held
    wait_valid(20);
    chk("stall_instr", 32'(instruction), 32'hA3FF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_hold", 32'(instruction), 32'hA3FF);
      chk("stall_noreq", 32'(imem_req), 0);
      chk("stall_pc", 32'(pc), 3);
      chk("stall_cnt", 32'(retired_count), 3);
    end
    push(13'd3, 13'd4);
    accept_pulse();
    chk("pc_after_stall", 32'(pc), 4);

    // pc_load without accept is ignored; jump on accept
    wait_valid(20);
    pc_load = 1'b1; jump_address = 13'h0777;
    @(negedge clk); @(negedge clk);
    chk("noacc_jump_pc", 32'(pc), 4);
    pc_load = 1'b0;
    push(13'd4, 13'd5);
    accept_pulse();
    wait_valid(20);
    chk("pc5", 32'(pc), 5);
    push(13'd5, 13'h0123);
    pc_load = 1'b1; jump_address = 13'h0123;
    accept_pulse();
    chk("jump_pc", 32'(pc), 32'h123);
    chk("jump_addr", 32'(imem_addr), 32'h123);

    // wrap from 1FFF to 0, with slow memory for the next fetch
    wait_valid(20);
    push(13'h0123, 13'h1FFF);
    pc_load = 1'b1; jump_address = 13'h1FFF;
    accept_pulse();
    wait_valid(20);
    chk("pc_top", 32'(pc), 32'h1FFF);
    gnt_dly = 4; rv_dly = 3; spur = 1'b1;
    push(13'h1FFF, 13'h0000);
    accept_pulse();
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_addr", 32'(imem_addr), 0);
    chk("count8", 32'(retired_count), 8);

    wait_valid(40);
    chk("slow_instr", 32'(instruction), 32'h4A10);
    gnt_dly = 0; spur = 1'b0; rv_dly = 5;
    push(13'd0, 13'd1);
    accept_pulse();
    chk("count9", 32'(retired_count), 9);

    // reset while waiting for rvalid; late rvalid must be dropped
    for (int i = 0; i < 10 && imem_req; i++) @(negedge clk);
    chk("in_wait", 32'(imem_req), 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_req", 32'(imem_req), 0);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_count", 32'(retired_count), 0);
    rv_dly = 0;
    addr_q.push_back(13'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    wait_valid(60);
    chk("post_rst_instr", 32'(instruction), 32'h4A10);
    chk("post_rst_pc", 32'(pc), 0);
    push(13'd0, 13'd1);
    accept_pulse();
    chk("post_rst_count", 32'(retired_count), 1);

    // saturation on the narrow-counter instance
    chk("sat_count", 32'(sat_count), 32'hF);
    repeat (10) @(negedge clk);
    chk("sat_hold", 32'(sat_count), 32'hF);
    repeat (4) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("addr_q_empty", 32'(addr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder/control unit. Holds the program counter and issues single-outstanding reads to instruction memory over a req/gnt + rvalid interface. Presents the fetched 16-bit instruction to the decoder with a valid/ready handshake. Applies the decoder's pc_load/jump_address only when the current instruction is accepted.

Parameters:
PC_WIDTH, 13, program counter and jump_address width (8K-word instruction space)
INSTR_WIDTH, 16, instruction word width
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request to instruction memory, registered
imem_addr  output  PC_WIDTH  read address, registered, equals pc while request outstanding
imem_gnt  input  1  memory accepted request (sampled only while imem_req=1)
imem_rvalid  input  1  read data valid (sampled only in S_WAIT)
imem_rdata  input  INSTR_WIDTH  read data
instruction  output  INSTR_WIDTH  instruction register to decoder
instr_valid  output  1  instruction register holds an unconsumed instruction
instr_ready  input  1  decoder consumes instruction this cycle
pc_load  input  1  from decoder: take branch/jump for current instruction
jump_address  input  PC_WIDTH  from decoder: branch/jump target
pc  output  PC_WIDTH  address of instruction currently held/being fetched
retired_count  output  CNT_WIDTH  number of accepted instructions, saturating

Behaviour:
- Reset (async, any time): state=S_IDLE, pc=0, imem_addr=0, imem_req=0, instruction=0, instr_valid=0, retired_count=0. Reset mid-transaction abandons the outstanding read; late rvalid after reset is ignored.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_VALID.
- S_IDLE: next edge -> S_REQ, imem_req<=1, imem_addr<=pc.
- S_REQ: imem_req=1 held stable with imem_addr until imem_gnt=1 at an edge; then imem_req<=0, -> S_WAIT. imem_rvalid ignored in S_REQ.
- S_WAIT: on edge with imem_rvalid=1: instruction<=imem_rdata, instr_valid<=1, -> S_VALID. Otherwise wait indefinitely.
- S_VALID: instruction/instr_valid stable until instr_ready=1 at an edge (accept). On accept: pc<=pc_load ? jump_address : pc+1 (mod 2^PC_WIDTH; 8191+1 -> 0); instr_valid<=0; retired_count+=1 unless all-ones; imem_req<=1, imem_addr<=next pc; -> S_REQ.
- pc_load/jump_address are don't-care except at accept; pc_load=1 with jump_address==pc+1 behaves identically to sequential.
- instr_ready while instr_valid=0 has no effect.
- instruction retains last value after accept (not cleared); only instr_valid qualifies it.
- Minimum throughput: 3 cycles/instruction (gnt same cycle as req, rvalid cycle after gnt, ready immediately).
- Exactly one read outstanding; no prefetch, so no flush needed on jump.

Decomposition:
- Shared package cpu_pkg: PC_WIDTH, INSTR_WIDTH constants; fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_VALID); pc_t, instr_t typedefs (reused by the control unit's jump_address/instruction ports).
- One sub-module: program_counter (pc register, next-pc mux selecting pc+1 vs jump_address, load enable = accept, async reset to 0).

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, ready tied 1, memory returns 16'h4A10 at addr 0 -> imem_addr 0,1,2 on successive requests; instr_valid pulses every 3 cycles; retired_count=3 after third accept.
- Hold instr_ready=0 for 5 cycles with instruction 16'hA3FF valid -> instruction/instr_valid stable, no new imem_req, pc unchanged, count unchanged; ready=1 -> pc+1.
- Accept at pc=5 with pc_load=1, jump_address=13'h0123 -> next imem_addr=13'h0123, pc=0x123; pc_load=1 while not accepting -> ignored.
- pc=13'h1FFF, pc_load=0, accept -> pc wraps to 0, imem_addr=0.
- imem_gnt delayed 4 cycles and rvalid delayed 3 cycles -> imem_req/imem_addr held stable throughout; spurious rvalid during S_REQ does not load instruction.
- Assert reset in S_WAIT, then rvalid arrives after release -> data ignored, pc=0, first request to addr 0; retired_count preloaded near 16'hFFFF saturates at 16'hFFFF.
